membus_arbiter: RTL

//  Shares the single MMIO request port between the instruction-fetch bus (I) and the data bus after the AMO unit (D).

---
 rtl/membus_arbiter_pkg.sv | 21 ++
 rtl/membus_arbiter_tag_fifo.sv | 56 +++++
 rtl/membus_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/membus_arbiter_pkg.sv
// Shared widths and tag types for the I/D memory-bus arbiter.
package membus_arbiter_pkg;

   localparam int unsigned XLEN              = 64;
   localparam int unsigned ILEN              = 32;
   localparam int unsigned MEMBUS_DATA_WIDTH = 64;

   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } membus_src_t;

   // hi selects the upper fetch word of a 64-bit beat.
   typedef struct packed {
      membus_src_t src;
      logic        hi;
   } arb_tag_t;

   localparam int unsigned TAG_WIDTH = $bits(arb_tag_t);

endpackage

// File: rtl/membus_arbiter_tag_fifo.sv
// In-order FIFO of issue tags; one entry per request awaiting its response.
module arb_tag_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 2,
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic            pop_i,
   output logic [Width-1:0] rdata_o,
   output logic            full_o,
   output logic            empty_o,
   output logic [CntW-1:0] count_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Depth is a power of two, so pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PtrW'(do_push);
      rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
      count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/membus_arbiter.sv
// Arbitrates fetch (I) and data (D) requests onto one MMIO port and routes
// in-order responses back to their issuer.
module membus_arbiter
   import membus_arbiter_pkg::*;
#(
   parameter int unsigned OUTSTANDING = 4,
   parameter int unsigned MAX_WAIT    = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_valid,
   output logic                         i_ready,
   input  logic [XLEN-1:0]              i_addr,
   output logic                         i_rvalid,
   output logic [ILEN-1:0]              i_rdata,
   input  logic                         d_valid,
   output logic                         d_ready,
   input  logic [XLEN-1:0]              d_addr,
   input  logic                         d_wen,
   input  logic [MEMBUS_DATA_WIDTH-1:0] d_wdata,
   input  logic [7:0]                   d_wmask,
   output logic                         d_rvalid,
   output logic [MEMBUS_DATA_WIDTH-1:0] d_rdata,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [XLEN-1:0]              m_addr,
   output logic                         m_wen,
   output logic [MEMBUS_DATA_WIDTH-1:0] m_wdata,
   output logic [7:0]                   m_wmask,
   input  logic                         m_rvalid,
   input  logic [MEMBUS_DATA_WIDTH-1:0] m_rdata,
   output logic                         err_orphan
);

   localparam int unsigned CntW = $clog2(OUTSTANDING + 1);
   localparam int unsigned SW   = $clog2(MAX_WAIT + 1);

   logic                 gnt_i, gnt_d, blocked, issue, pop;
   logic                 fifo_full, fifo_empty;
   logic [CntW-1:0]      count;
   logic [TAG_WIDTH-1:0] fifo_rdata;
   arb_tag_t             push_tag, head_tag;
   logic [SW-1:0]        starve_cnt_q, starve_cnt_d;
   logic                 err_orphan_q, err_orphan_d;
   logic                 starve_max;

   assign starve_max = (starve_cnt_q == SW'(MAX_WAIT));
   assign head_tag   = arb_tag_t'(fifo_rdata);

   always_comb begin
      gnt_i   = i_valid & (~d_valid | starve_max);
      gnt_d   = d_valid & ~gnt_i;
      // Uses the pre-pop occupancy: a same-cycle response does not free a slot.
      blocked = fifo_full;
      m_valid = (i_valid | d_valid) & ~blocked;
      i_ready = gnt_i & m_ready & ~blocked;
      d_ready = gnt_d & m_ready & ~blocked;
      issue   = m_valid & m_ready;

      m_addr  = gnt_i ? i_addr : d_addr;
      m_wen   = gnt_d & d_wen;
      m_wdata = gnt_d ? d_wdata : '0;
      m_wmask = gnt_d ? d_wmask : '0;

      push_tag.src = gnt_i ? SRC_I : SRC_D;
      push_tag.hi  = gnt_i ? i_addr[2] : d_addr[2];

      pop      = m_rvalid & ~fifo_empty;
      i_rvalid = pop & (head_tag.src == SRC_I);
      d_rvalid = pop & (head_tag.src == SRC_D);
      i_rdata  = head_tag.hi ? m_rdata[63:32] : m_rdata[31:0];
      d_rdata  = m_rdata;

      err_orphan_d = err_orphan_q | (m_rvalid & (count == '0));

      starve_cnt_d = starve_cnt_q;
      if (!i_valid || i_ready) begin
         starve_cnt_d = '0;
      end else if (d_valid && !starve_max) begin
         starve_cnt_d = starve_cnt_q + SW'(1);
      end
   end

   assign err_orphan = err_orphan_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt_q <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         err_orphan_q <= err_orphan_d;
      end
   end

   arb_tag_fifo #(
      .Depth (OUTSTANDING),
      .Width (TAG_WIDTH)
   ) u_tag_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (issue),
      .wdata_i (push_tag),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (count)
   );

endmodule
